// File: rtl/ir_scan_scheduler_if.sv
// Report handshake between the scan scheduler and the serial report engine.
//   report_req    scheduler -> reporter  level, high while a slot's results await reporting
//   report_tx_id  scheduler -> reporter  index of the transmitter being reported
//   report_done   reporter -> scheduler  one-clk pulse: line sent, counters cleared
interface ir_scan_scheduler_if;
  logic       report_req;
  logic [3:0] report_tx_id;
  logic       report_done;

  modport master (output report_req, output report_tx_id, input report_done);
  modport slave  (input report_req, input report_tx_id, output report_done);
endinterface

// File: rtl/ir_scan_scheduler.sv
// Proximity-sensor scan sequencer. Picks transmitters round-robin from an enable
// mask, times each slot's burst and quiet windows in modulation half-cycles, then
// hands the slot to the report engine and waits for it to finish.
// Ports:
//   clk, reset_n     clock and asynchronous active-low reset
//   mod_edge         one-clk pulse per modulation half-cycle
//   scan_run         level: keep scanning / stop after current slot
//   tx_mask          transmitter enable mask, evaluated only when selecting
//   burst_cycles     burst length in half-cycles (0 acts as 1), latched at slot start
//   quiet_cycles     listen length in half-cycles (0 skips QUIET), latched at slot start
//   rpt              report handshake (report_req / report_tx_id / report_done)
//   tx_select        one-hot driver enable, only during BURST
//   sample_en        RX counters may accumulate (BURST and QUIET)
//   frame_start      one-clk pulse when a new pass over the mask begins
//   idle             high in IDLE
module ir_scan_scheduler #(
  parameter int kTxCount   = 12,
  parameter int kTimerBits = 12
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  mod_edge,
  input  logic                  scan_run,
  input  logic [kTxCount-1:0]   tx_mask,
  input  logic [kTimerBits-1:0] burst_cycles,
  input  logic [kTimerBits-1:0] quiet_cycles,
  ir_scan_scheduler_if.master   rpt,
  output logic [kTxCount-1:0]   tx_select,
  output logic                  sample_en,
  output logic                  frame_start,
  output logic                  idle
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_BURST  = 2'd1;
  localparam logic [1:0] S_QUIET  = 2'd2;
  localparam logic [1:0] S_REPORT = 2'd3;

  logic [1:0]            state;
  logic [3:0]            cur_tx;
  logic [kTimerBits-1:0] timer;
  logic [kTimerBits-1:0] burst_lat;
  logic [kTimerBits-1:0] quiet_lat;

  // Candidate masks: enabled transmitters strictly above cur_tx, and one-hot of the pick.
  logic [kTxCount-1:0] higher;
  logic [kTxCount-1:0] next_onehot;
  logic [3:0]          next_tx;
  logic                next_wrap;
  logic                start_slot;

  genvar gi;
  generate
    for (gi = 0; gi < kTxCount; gi++) begin : g_sel
      assign higher[gi]      = (4'(gi) > cur_tx);
      assign next_onehot[gi] = (next_tx == 4'(gi));
    end
  endgenerate

  // Lowest enabled index above cur_tx; if there is none the pass wraps to the
  // lowest enabled index overall, which is what marks a new frame.
  always_comb begin
    logic [kTxCount-1:0] above;
    logic [3:0]          pick_hi;
    logic [3:0]          pick_lo;
    logic                hi_found;
    above    = tx_mask & higher;
    pick_hi  = '0;
    pick_lo  = '0;
    hi_found = 1'b0;
    for (int i = kTxCount - 1; i >= 0; i--) begin
      if (above[i]) begin
        pick_hi  = 4'(i);
        hi_found = 1'b1;
      end
      if (tx_mask[i]) begin
        pick_lo = 4'(i);
      end
    end
    next_tx   = hi_found ? pick_hi : pick_lo;
    next_wrap = !hi_found;
  end

  assign start_slot = scan_run && (|tx_mask) &&
                      ((state == S_IDLE) || (state == S_REPORT && rpt.report_done));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state            <= S_IDLE;
      cur_tx           <= 4'(kTxCount - 1);
      timer            <= '0;
      burst_lat        <= '0;
      quiet_lat        <= '0;
      tx_select        <= '0;
      sample_en        <= 1'b0;
      rpt.report_req   <= 1'b0;
      rpt.report_tx_id <= '0;
      frame_start      <= 1'b0;
      idle             <= 1'b1;
    end else begin
      frame_start <= 1'b0;
      if (start_slot) begin
        // A mod_edge coinciding with the slot start is deliberately not counted.
        state          <= S_BURST;
        cur_tx         <= next_tx;
        timer          <= '0;
        burst_lat      <= (burst_cycles == '0) ? kTimerBits'(1) : burst_cycles;
        quiet_lat      <= quiet_cycles;
        tx_select      <= next_onehot;
        sample_en      <= 1'b1;
        rpt.report_req <= 1'b0;
        frame_start    <= (state == S_IDLE) || next_wrap;
        idle           <= 1'b0;
      end else begin
        case (state)
          S_BURST: begin
            if (mod_edge) begin
              if (timer == burst_lat - kTimerBits'(1)) begin
                timer     <= '0;
                tx_select <= '0;
                if (quiet_lat == '0) begin
                  state            <= S_REPORT;
                  sample_en        <= 1'b0;
                  rpt.report_req   <= 1'b1;
                  rpt.report_tx_id <= cur_tx;
                end else begin
                  state <= S_QUIET;
                end
              end else begin
                timer <= timer + kTimerBits'(1);
              end
            end
          end
          S_QUIET: begin
            if (mod_edge) begin
              if (timer == quiet_lat - kTimerBits'(1)) begin
                timer            <= '0;
                state            <= S_REPORT;
                sample_en        <= 1'b0;
                rpt.report_req   <= 1'b1;
                rpt.report_tx_id <= cur_tx;
              end else begin
                timer <= timer + kTimerBits'(1);
              end
            end
          end
          S_REPORT: begin
            // Reaching here with report_done set means no further slot may start.
            if (rpt.report_done) begin
              state          <= S_IDLE;
              rpt.report_req <= 1'b0;
              idle           <= 1'b1;
            end
          end
          default: begin
            state <= S_IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ir_scan_scheduler.sv
// Self-checking bench for ir_scan_scheduler: directed scenarios followed by
// randomized slots, each slot checked against a round-robin reference model.
module tb_ir_scan_scheduler;

  localparam int N = 12;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          mod_edge;
  logic          scan_run;
  logic [N-1:0]  tx_mask;
  logic [11:0]   burst_cycles;
  logic [11:0]   quiet_cycles;
  logic [N-1:0]  tx_select;
  logic          sample_en;
  logic          frame_start;
  logic          idle;

  ir_scan_scheduler_if rpt ();

  ir_scan_scheduler #(.kTxCount(N), .kTimerBits(12)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .mod_edge     (mod_edge),
    .scan_run     (scan_run),
    .tx_mask      (tx_mask),
    .burst_cycles (burst_cycles),
    .quiet_cycles (quiet_cycles),
    .rpt          (rpt),
    .tx_select    (tx_select),
    .sample_en    (sample_en),
    .frame_start  (frame_start),
    .idle         (idle)
  );

  always #5 clk = ~clk;

  // Random modulation half-cycle pulses, changed just after each rising edge.
  initial begin
    mod_edge = 1'b0;
    forever begin
      @(posedge clk);
      #1 mod_edge = ($urandom_range(0, 2) == 0);
    end
  end

  initial begin
    #300000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  int n_vec = 0;
  int n_err = 0;
  int m_cur;   // model: last transmitter served
  bit m_idle;  // model: next slot starts from IDLE

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, got, exp);
    end
  endtask

  // Reference round-robin: scan forward from cur, modulo N.
  function automatic int model_next(input int cur, input logic [N-1:0] m, output bit wrap);
    int idx;
    wrap = 1'b0;
    for (int k = 1; k <= N; k++) begin
      idx = (cur + k) % N;
      if (m[idx]) begin
        wrap = (idx <= cur);
        return idx;
      end
    end
    return 0;
  endfunction

  // Follows one slot from its first cycle through the report handshake.
  // Entered at a negedge where the slot is expected to be already visible.
  // action: 0 none, 1 drop scan_run, 2 burst=9 and disable active TX,
  //         3 random config change plus stray report_done.
  // mode:   0 continue, 1 stop afterwards (expect IDLE), 2 reset during REPORT.
  task automatic run_slot(input int action, input int mode);
    int waited, exp_tx, exp_b, exp_q, n_tx, n_smp, n_quiet, guard, bad, hold_bad;
    bit wrap, exp_fs;
    waited = 0;
    while (tx_select == '0 && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    check_val("start_gap", waited, 0);
    exp_tx = model_next(m_cur, tx_mask, wrap);
    exp_fs = m_idle || wrap;
    m_cur  = exp_tx;
    m_idle = 1'b0;
    exp_b  = (burst_cycles == 0) ? 1 : int'(burst_cycles);
    exp_q  = int'(quiet_cycles);
    check_val("tx_select", 32'(tx_select), 32'(1) << exp_tx);
    check_val("frame_start", 32'(frame_start), 32'(exp_fs));
    check_val("idle_in_slot", 32'(idle), 0);
    case (action)
      1: scan_run = 1'b0;
      2: begin
        burst_cycles    = 12'd9;
        tx_mask[exp_tx] = 1'b0;
      end
      3: begin
        burst_cycles    = 12'($urandom_range(0, 7));
        quiet_cycles    = 12'($urandom_range(0, 4));
        tx_mask         = 12'($urandom_range(1, 4095));
        rpt.report_done = 1'b1;
      end
      default: ;
    endcase
    n_tx = 0; n_smp = 0; n_quiet = 0; guard = 0; bad = 0;
    while (rpt.report_req == 1'b0 && guard < 3000) begin
      if (tx_select != '0 && tx_select != (N'(1) << exp_tx)) bad++;
      if (guard > 0 && frame_start) bad++;
      if (tx_select != '0 && !sample_en) bad++;
      if (tx_select != '0 && mod_edge) n_tx++;
      if (sample_en && mod_edge) n_smp++;
      if (sample_en && tx_select == '0 && mod_edge) n_quiet++;
      @(negedge clk);
      rpt.report_done = 1'b0;
      guard++;
    end
    check_val("report_req", 32'(rpt.report_req), 1);
    check_val("burst_edges", n_tx, exp_b);
    check_val("sample_edges", n_smp, exp_b + exp_q);
    check_val("quiet_edges", n_quiet, exp_q);
    check_val("slot_glitch", bad, 0);
    check_val("report_tx_id", 32'(rpt.report_tx_id), exp_tx);
    check_val("report_outs", {sample_en, 20'd0, tx_select}, 0);
    $display("slot tx=%0d burst=%0d quiet=%0d edges=%0d/%0d fs=%0d", exp_tx, exp_b, exp_q,
             n_tx, n_smp, frame_start);
    if (mode == 2) begin
      reset_n = 1'b0;
      #1;
      check_val("rst_report_req", 32'(rpt.report_req), 0);
      check_val("rst_idle", 32'(idle), 1);
      check_val("rst_outs", {sample_en, frame_start, rpt.report_tx_id, 14'd0, tx_select}, 0);
      rpt.report_done = 1'b1;
      @(negedge clk);
      rpt.report_done = 1'b0;
      scan_run        = 1'b0;
      reset_n         = 1'b1;
      @(negedge clk);
      rpt.report_done = 1'b1;
      @(negedge clk);
      rpt.report_done = 1'b0;
      @(negedge clk);
      check_val("stray_done_req", 32'(rpt.report_req), 0);
      check_val("stray_done_idle", 32'(idle), 1);
      m_cur  = N - 1;
      m_idle = 1'b1;
      return;
    end
    hold_bad = 0;
    repeat (3) begin
      @(negedge clk);
      if (!rpt.report_req || rpt.report_tx_id != 4'(exp_tx) || sample_en) hold_bad++;
    end
    check_val("report_hold", hold_bad, 0);
    if (mode == 1) scan_run = 1'b0;
    rpt.report_done = 1'b1;
    @(negedge clk);
    rpt.report_done = 1'b0;
    if (mode == 1) begin
      check_val("stop_idle", 32'(idle), 1);
      check_val("stop_outs", {rpt.report_req, sample_en, 18'd0, tx_select}, 0);
      m_idle = 1'b1;
    end
  endtask

  initial begin
    int any;
    reset_n = 1'b0; scan_run = 1'b0; tx_mask = '0;
    burst_cycles = '0; quiet_cycles = '0; rpt.report_done = 1'b0;
    m_cur = N - 1; m_idle = 1'b1;
    repeat (3) @(negedge clk);
    check_val("reset_idle", 32'(idle), 1);
    check_val("reset_tx_select", 32'(tx_select), 0);
    check_val("reset_misc", {sample_en, frame_start, rpt.report_req, rpt.report_tx_id}, 0);
    reset_n = 1'b1;
    @(negedge clk);
    check_val("idle_no_run", 32'(idle), 1);

    // Alternating TX0/TX2, frame_start on TX0 only.
    tx_mask = 12'h005; burst_cycles = 12'd4; quiet_cycles = 12'd2; scan_run = 1'b1;
    @(negedge clk);
    run_slot(0, 0);
    run_slot(0, 0);
    run_slot(0, 1);

    // Empty mask keeps IDLE; then a single TX11 wraps onto itself.
    tx_mask = '0; scan_run = 1'b1; any = 0;
    repeat (20) begin
      @(negedge clk);
      if (tx_select != '0 || sample_en || rpt.report_req || frame_start || !idle) any++;
    end
    check_val("empty_mask_idle", any, 0);
    tx_mask = 12'h800;
    @(negedge clk);
    run_slot(0, 0);
    run_slot(0, 1);

    // Zero burst and zero quiet: one edge, straight to REPORT.
    tx_mask = 12'h001; burst_cycles = 12'd0; quiet_cycles = 12'd0; scan_run = 1'b1;
    @(negedge clk);
    run_slot(0, 0);
    run_slot(0, 1);

    // Stop during TX1, resume on TX2; burst/mask change mid-slot on TX3.
    tx_mask = 12'h00F; burst_cycles = 12'd4; quiet_cycles = 12'd2; scan_run = 1'b1;
    @(negedge clk);
    run_slot(1, 1);
    scan_run = 1'b1;
    @(negedge clk);
    run_slot(0, 0);
    run_slot(2, 0);
    run_slot(0, 1);

    // Reset while reporting.
    tx_mask = 12'h00F; burst_cycles = 12'd2; quiet_cycles = 12'd1; scan_run = 1'b1;
    @(negedge clk);
    run_slot(0, 2);

    // Randomized slots.
    tx_mask = 12'($urandom_range(1, 4095));
    burst_cycles = 12'($urandom_range(0, 7));
    quiet_cycles = 12'($urandom_range(0, 4));
    scan_run = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 40; i++) begin
      int act, md;
      act = ($urandom_range(0, 1) == 1) ? 3 : 0;
      md  = (i == 39 || $urandom_range(0, 7) == 0) ? 1 : 0;
      run_slot(act, md);
      if (md == 1 && i < 39) begin
        scan_run = 1'b1;
        @(negedge clk);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
